// File: rtl/ntt_mdc_commutator.sv
// Radix-2 MDC NTT commutator: lane 1 and switch lane 0 each pass through
// a D-beat delay line; a frame ends with D zero-input drain beats.
module ntt_mdc_commutator #(
    parameter int LOGQ       = 32,
    parameter int DEPTH      = 4,
    parameter int RAM_THRESH = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_last,
    input  logic [LOGQ-1:0] in_0,
    input  logic [LOGQ-1:0] in_1,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGQ-1:0] out_0,
    output logic [LOGQ-1:0] out_1,
    output logic            out_last,
    output logic            busy
);
    localparam int LOG_D = $clog2(DEPTH);
    localparam int KW = LOG_D + 1;
    localparam logic [KW-1:0] K_D1 = KW'(DEPTH - 1);
    localparam logic [KW-1:0] K_ONE = KW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [KW-1:0]   dcnt_q, dcnt_d;
    logic            primed_q, primed_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [LOGQ-1:0] out_0_q, out_0_d;
    logic [LOGQ-1:0] out_1_q, out_1_d;

    logic            draining, can_move;
    logic            adv_in, adv_dr, adv;
    logic            drain_end, sel;
    logic [LOGQ-1:0] lane0, lane1;
    logic [LOGQ-1:0] sw0, sw1;
    logic [LOGQ-1:0] a_out, b_out;

    assign draining  = (state_q == S_DRAIN);
    assign can_move  = out_ready | ~out_valid_q;
    assign in_ready  = rst & ~draining & can_move;
    assign adv_in    = in_valid & in_ready;
    assign adv_dr    = draining & can_move;
    assign adv       = adv_in | adv_dr;
    assign drain_end = adv_dr & (dcnt_q == K_D1);
    assign sel       = k_q[LOG_D];

    // drain beats push zeros through both lanes
    assign lane0 = draining ? '0 : in_0;
    assign lane1 = draining ? '0 : in_1;
    assign sw0   = sel ? a_out : lane0;
    assign sw1   = sel ? lane0 : a_out;

    generate
        if (DEPTH <= RAM_THRESH) begin : g_reg
            logic [LOGQ-1:0] a_line_q [DEPTH];
            logic [LOGQ-1:0] b_line_q [DEPTH];

            always_ff @(posedge clk) begin
                if (adv) begin
                    a_line_q[0] <= lane1;
                    b_line_q[0] <= sw0;
                    for (int i = 1; i < DEPTH; i++) begin
                        a_line_q[i] <= a_line_q[i-1];
                        b_line_q[i] <= b_line_q[i-1];
                    end
                end
            end

            assign a_out = a_line_q[DEPTH-1];
            assign b_out = b_line_q[DEPTH-1];
        end else begin : g_ram
            // k mod D is a circular pointer: each slot is read D beats after its write
            logic [LOGQ-1:0] a_mem [DEPTH];
            logic [LOGQ-1:0] b_mem [DEPTH];
            logic [LOG_D-1:0] ptr;

            assign ptr = k_q[LOG_D-1:0];

            always_ff @(posedge clk) begin
                if (adv) begin
                    a_mem[ptr] <= lane1;
                    b_mem[ptr] <= sw0;
                end
            end

            assign a_out = a_mem[ptr];
            assign b_out = b_mem[ptr];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        dcnt_d   = dcnt_q;
        primed_d = primed_q;
        if (adv) begin
            k_d = k_q + K_ONE;
            if (k_q == K_D1) primed_d = 1'b1;
        end
        case (state_q)
            S_IDLE, S_FILL: begin
                if (adv_in) begin
                    if (in_last) state_d = S_DRAIN;
                    else if (k_q == K_D1) state_d = S_RUN;
                    else state_d = S_FILL;
                end
            end
            S_RUN: begin
                if (adv_in && in_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (adv_dr) begin
                    dcnt_d = dcnt_q + K_ONE;
                    if (dcnt_q == K_D1) begin
                        state_d  = S_IDLE;
                        k_d      = '0;
                        dcnt_d   = '0;
                        primed_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // only beats issued after D pushes carry a defined pair
    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_0_d     = out_0_q;
        out_1_d     = out_1_q;
        if (adv) begin
            out_valid_d = primed_q;
            out_last_d  = drain_end;
            if (primed_q) begin
                out_0_d = b_out;
                out_1_d = sw1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            dcnt_q      <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_0_q     <= '0;
            out_1_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            dcnt_q      <= dcnt_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_0_q     <= out_0_d;
            out_1_q     <= out_1_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_0     = out_0_q;
    assign out_1     = out_1_q;
    assign busy      = (state_q != S_IDLE);

endmodule
